multiplier_unit: RTL and testbench

MULTIPLIER_UNIT -- requirements
Module: multiplier_unit

---
 rtl/mips_func_pkg.sv | 25 ++
 rtl/hilo_reg.sv | 38 +++
 rtl/multiplier_unit.sv | 155 +++++++++++++++
 tb/tb_multiplier_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_func_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_func_pkg
// Description : Shared ALU-control function codes and the multiplier FSM
//               state encoding used by the multiply unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_func_pkg;

    // Function codes carried on SignaltoMUT
    localparam logic [5:0] c_FUNC_NOP   = 6'b000000;
    localparam logic [5:0] c_FUNC_MFHI  = 6'b010000;
    localparam logic [5:0] c_FUNC_MFLO  = 6'b010010;
    localparam logic [5:0] c_FUNC_MULT  = 6'b011000;
    localparam logic [5:0] c_FUNC_MULTU = 6'b011001;

    // Multiplier controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

endpackage : mips_func_pkg
`default_nettype wire

// File: rtl/hilo_reg.sv
`default_nettype none
// ============================================================================
// Module      : hilo_reg
// Description : HI/LO result register pair with a shared write enable and
//               synchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    // Capture both halves together when the multiplier commits a result
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (we) begin
            r_hi <= hi_in;
            r_lo <= lo_in;
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule : hilo_reg
`default_nettype wire

// File: rtl/multiplier_unit.sv
`default_nettype none
// ============================================================================
// Module      : multiplier_unit
// Description : Iterative shift-add multiplier (one product bit per cycle)
//               with HI/LO result registers and MFHI/MFLO read-out.
//               Optional macro MULT_SIGNED_EN adds the signed MULT command.
// Revision    : 1.0 - initial release
// ============================================================================
module multiplier_unit
    import mips_func_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       SignaltoMUT,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy,
    output logic             done
);

    localparam int         CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);

    mul_state_t         r_state;
    mul_state_t         w_state_nxt;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done;
    logic [WIDTH-1:0]   r_data_out;

    logic               w_start;
    logic               w_last;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod_step;
    logic [2*WIDTH-1:0] w_result;
    logic [WIDTH-1:0]   w_load_a;
    logic [WIDTH-1:0]   w_load_b;
    logic [WIDTH-1:0]   w_hi;
    logic [WIDTH-1:0]   w_lo;
    logic               w_hilo_we;

`ifdef MULT_SIGNED_EN
    logic               r_sign;
    logic               w_signed_cmd;
    logic               w_load_sign;

    // Signed commands multiply magnitudes and remember the result sign
    always_comb begin
        w_signed_cmd = (SignaltoMUT == c_FUNC_MULT);
        w_load_a     = (w_signed_cmd && dataA[WIDTH-1]) ? (~dataA + 1'b1) : dataA;
        w_load_b     = (w_signed_cmd && dataB[WIDTH-1]) ? (~dataB + 1'b1) : dataB;
        w_load_sign  = w_signed_cmd && (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
        w_start      = (r_state == ST_IDLE) &&
                       ((SignaltoMUT == c_FUNC_MULTU) || w_signed_cmd);
        w_result     = r_sign ? (~r_prod + 1'b1) : r_prod;
    end
`else
    // Unsigned-only build: operands load as-is, product is the result
    always_comb begin
        w_load_a = dataA;
        w_load_b = dataB;
        w_start  = (r_state == ST_IDLE) && (SignaltoMUT == c_FUNC_MULTU);
        w_result = r_prod;
    end
`endif

    // One shift-add step; the extra sum bit keeps the carry out of the add
    always_comb begin
        w_sum       = {1'b0, r_prod[2*WIDTH-1:WIDTH]} +
                      (r_prod[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
        w_prod_step = {w_sum, r_prod[WIDTH-1:1]};
        w_last      = (r_cnt == c_CNT_LAST);
    end

    // Next-state logic; commands are only accepted in IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_hilo_we   = 1'b0;
        case (r_state)
            ST_IDLE: if (w_start) w_state_nxt = ST_BUSY;
            ST_BUSY: if (w_last)  w_state_nxt = ST_DONE;
            ST_DONE: begin
                w_hilo_we   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Multiplier datapath: operand latch, product shift register, counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
`ifdef MULT_SIGNED_EN
            r_sign  <= 1'b0;
`endif
        end else if (w_start) begin
            r_mcand <= w_load_a;
            r_prod  <= {{WIDTH{1'b0}}, w_load_b};
            r_cnt   <= '0;
`ifdef MULT_SIGNED_EN
            r_sign  <= w_load_sign;
`endif
        end else if (r_state == ST_BUSY) begin
            r_prod <= w_prod_step;
            r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    // Done pulse follows the cycle in which HI/LO are committed
    always_ff @(posedge clk) begin
        if (reset) r_done <= 1'b0;
        else       r_done <= w_hilo_we;
    end

    // MFHI/MFLO read-out, only honoured while the unit is idle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_out <= '0;
        end else if (r_state == ST_IDLE) begin
            if (SignaltoMUT == c_FUNC_MFHI)      r_data_out <= w_hi;
            else if (SignaltoMUT == c_FUNC_MFLO) r_data_out <= w_lo;
        end
    end

    hilo_reg #(
        .WIDTH (WIDTH)
    ) u_hilo (
        .clk   (clk),
        .reset (reset),
        .we    (w_hilo_we),
        .hi_in (w_result[2*WIDTH-1:WIDTH]),
        .lo_in (w_result[WIDTH-1:0]),
        .hi    (w_hi),
        .lo    (w_lo)
    );

    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;
    assign dataOut = r_data_out;

endmodule : multiplier_unit
`default_nettype wire

// File: tb/tb_multiplier_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiplier_unit
// Description : Self-checking bench for multiplier_unit: table of unsigned
//               products plus hand sequences for ignored commands, reset
//               mid-multiply and the signed/no-op MULT code (MULT_SIGNED_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplier_unit;

    localparam int WIDTH = 32;
    localparam logic [5:0] NOP   = 6'b000000;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MFLO  = 6'b010010;
    localparam logic [5:0] MULT  = 6'b011000;
    localparam logic [5:0] MULTU = 6'b011001;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       code;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] data_out;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs [7];

    multiplier_unit #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .SignaltoMUT (code),
        .dataA       (a),
        .dataB       (b),
        .dataOut     (data_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Advance one edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_reg(input logic [5:0] c, output logic [31:0] val);
        code = c;
        step();
        code = NOP;
        val  = data_out;
    endtask

    // Issue a multiply, check busy/latency, then read LO and HI back
    task automatic mult_run(input string name, input logic [5:0] c,
                            input logic [31:0] va, input logic [31:0] vb,
                            input logic [31:0] ehi, input logic [31:0] elo);
        int cnt;
        bit got;
        logic [31:0] rd;
        code = c; a = va; b = vb;
        step();
        code = NOP; a = '0; b = '0;
        check({name, " busy"}, busy, 1);
        cnt = 0;
        got = 0;
        while (cnt < WIDTH + 5 && !got) begin
            step();
            cnt++;
            if (done) got = 1;
        end
        check({name, " latency"}, cnt, WIDTH + 1);
        step();
        check({name, " done_pulse"}, done, 0);
        read_reg(MFLO, rd);
        check({name, " LO"}, rd, elo);
        read_reg(MFHI, rd);
        check({name, " HI"}, rd, ehi);
    endtask

    initial begin : main
        logic [31:0] rd;
        int cnt;
        int done_seen;

        vecs[0] = '{32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[3] = '{32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
        vecs[4] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0000, 32'hFFFE_0001};
        vecs[5] = '{32'h0000_0001, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[6] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};

        // Reset state
        reset = 1'b1; code = NOP; a = '0; b = '0;
        step();
        step();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset dataOut", data_out, 0);
        reset = 1'b0;
        read_reg(MFHI, rd);
        check("reset HI", rd, 0);
        read_reg(MFLO, rd);
        check("reset LO", rd, 0);

        // Table of unsigned products
        for (int i = 0; i < 7; i++) begin
            mult_run($sformatf("vec%0d", i), MULTU, vecs[i].a, vecs[i].b,
                     vecs[i].hi, vecs[i].lo);
        end

        // Commands issued while busy are ignored (MULTU and MFLO)
        code = MULTU; a = 32'd7; b = 32'd9;
        step();
        code = NOP; a = '0; b = '0;
        cnt = 0;
        done_seen = 0;
        while (cnt < WIDTH + 5 && done_seen == 0) begin
            if (cnt == 10) begin code = MULTU; a = 32'd2; b = 32'd2; end
            else if (cnt == 12) code = MFLO;
            else code = NOP;
            step();
            cnt++;
            if (cnt == 13) check("busy MFLO ignored", data_out, 32'h0000_0001);
            if (done) done_seen = 1;
        end
        code = NOP; a = '0; b = '0;
        check("ignore latency", cnt, WIDTH + 1);
        step();
        read_reg(MFLO, rd);
        check("ignore LO", rd, 32'd63);
        read_reg(MFHI, rd);
        check("ignore HI", rd, 32'd0);

        // Reset during a multiply aborts it
        code = MULTU; a = 32'd6; b = 32'd7;
        step();
        code = NOP; a = '0; b = '0;
        for (int i = 0; i < 14; i++) step();
        check("abort busy before", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort busy", busy, 0);
        done_seen = 0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            step();
            if (done) done_seen++;
        end
        check("abort no done", done_seen, 0);
        read_reg(MFLO, rd);
        check("abort LO", rd, 0);
        read_reg(MFHI, rd);
        check("abort HI", rd, 0);

`ifdef MULT_SIGNED_EN
        mult_run("signed -2*3", MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        mult_run("signed -3*-5", MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0, 32'd15);
        mult_run("signed 4*-1", MULT, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
`else
        mult_run("pre-noop", MULTU, 32'd3, 32'd5, 32'h0, 32'hF);
        code = MULT; a = 32'hFFFF_FFFE; b = 32'd3;
        step();
        code = NOP; a = '0; b = '0;
        check("noop busy", busy, 0);
        done_seen = 0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            step();
            if (done) done_seen++;
        end
        check("noop no done", done_seen, 0);
        read_reg(MFLO, rd);
        check("noop LO", rd, 32'hF);
        read_reg(MFHI, rd);
        check("noop HI", rd, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_multiplier_unit
`default_nettype wire
